xadac_resp_sched: RTL and testbench
===================================

Name: xadac_resp_sched

Overview:
- Schedules the XADAC functional units' response channels onto the single coprocessor response port.
- Round-robin arbitration with one registered output slot.
- Per-unit outstanding-request credit counters throttle issue to each unit.
- Sits between the unit array (vactv, vbias, vload, vmacc) and the core-side response interface; replaces the ad-hoc response demux.

Parameters:
- NoUnits, 4, number of unit response channels (>=2).
- IdWidth, 4, response ID width.
- XlenWidth, 32, scalar rd width.
- VlenWidth, 256, vector vd width.
- MaxOutstanding, 4, max in-flight requests per unit (>=1); CntW = $clog2(MaxOutstanding+1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- req_issue  in  NoUnits  bit i: request handshake to unit i completed this cycle
- req_allow  out  NoUnits  bit i: unit i may accept a new request (credit available)
- unit_resp_valid  in  NoUnits  per-unit response valid
- unit_resp_ready  out  NoUnits  per-unit response ready
- unit_resp_id  in  NoUnits*IdWidth  packed, unit i at [i*IdWidth +: IdWidth]
- unit_resp_rd  in  NoUnits*XlenWidth  packed scalar results
- unit_resp_vd  in  NoUnits*VlenWidth  packed vector results
- unit_resp_rd_write  in  NoUnits  rd write-enable per unit
- unit_resp_vd_write  in  NoUnits  vd write-enable per unit
- resp_valid  out  1  registered response valid to core
- resp_ready  in  1  core ready
- resp_id  out  IdWidth  registered ID
- resp_rd  out  XlenWidth  registered rd
- resp_vd  out  VlenWidth  registered vd
- resp_rd_write  out  1  registered rd write-enable
- resp_vd_write  out  1  registered vd write-enable
- idle  out  1  all counters zero and output slot empty
- err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst high at posedge):
  - resp_valid=0; resp_id/rd/vd/rd_write/vd_write=0.
  - rr_ptr=0; all counters=0; err=0.
  - idle=1 and req_allow=all-ones on the cycle after reset.
  - Asserting rst mid-transfer discards the held response and all counts.
- Slot free: slot_free = !resp_valid || resp_ready.
- Grant:
  - Combinational, round-robin.
  - Winner is the first i with unit_resp_valid[i], searching from rr_ptr upward, wrapping NoUnits-1 -> 0.
  - unit_resp_ready[i] = (i == winner) && any valid && slot_free; all other ready bits are 0.
- Accept (unit_resp_valid[w] && unit_resp_ready[w]):
  - Next cycle, the output registers load unit w's payload and resp_valid=1.
  - rr_ptr <= (w+1) mod NoUnits, so the last winner gets lowest priority.
- Drain and bypass:
  - resp_valid && resp_ready with no new accept: resp_valid <= 0.
  - resp_valid && resp_ready with a simultaneous accept: the slot reloads and resp_valid stays 1, giving one response per cycle of throughput.
- Stall: output payload is held stable while resp_valid && !resp_ready.
- Latency: unit accept -> resp_valid is exactly 1 cycle.
- Counters:
  - cnt[i] +1 on req_issue[i].
  - cnt[i] -1 on response accept from unit i.
  - Both in the same cycle: unchanged.
- Credit: req_allow[i] = (cnt[i] < MaxOutstanding), combinational from the registered count.
- Overflow: req_issue[i] with cnt[i]==MaxOutstanding and no simultaneous decrement -> counter saturates, err <= 1.
- Underflow: response accepted from unit i with cnt[i]==0 and no simultaneous issue -> response still forwarded, counter stays 0, err <= 1.
- err: cleared only by rst.
- idle: (all cnt==0) && !resp_valid.

Test Plan:
- Reset, then idle: after rst, idle=1, req_allow=4'b1111, resp_valid=0, err=0.
- Single response:
  - req_issue=4'b0100 (cnt[2]=1, idle=0).
  - Unit2 valid id=5, vd_write=1, resp_ready=1 -> unit_resp_ready=4'b0100 same cycle.
  - Next cycle resp_valid=1, resp_id=5, resp_vd_write=1; cnt[2]=0; idle=1 after drain.
- Round-robin fairness:
  - All four units hold valid with outstanding credit, resp_ready=1.
  - Grant order 0,1,2,3,0; one resp_valid beat per cycle, no bubbles.
- Backpressure:
  - resp_ready=0 for 3 cycles with units 1 and 3 valid.
  - Output payload held; unit_resp_ready=0 while slot full.
  - On resp_ready=1, the next winner is unit 1 or 3 according to rr_ptr, loaded the same cycle.
- Credit limit:
  - 4 issues to unit 0 -> req_allow[0]=0.
  - Fifth issue -> err=1, cnt[0] stays 4.
  - Issue plus response in the same cycle at cnt=4 -> count stays 4, err unchanged.
- Reset mid-operation: rst while resp_valid=1 and cnt[1]=2 -> next cycle resp_valid=0, cnt all 0, rr_ptr=0.

Source files
------------

// File: rtl/xadac_resp_sched.sv
// XADAC response scheduler: round-robin merge of unit response channels into one
// registered core response slot, with per-unit outstanding-request credit counters.
`timescale 1ns/1ps
module xadac_resp_sched #(
  parameter int NoUnits        = 4,
  parameter int IdWidth        = 4,
  parameter int XlenWidth      = 32,
  parameter int VlenWidth      = 256,
  parameter int MaxOutstanding = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NoUnits-1:0]             req_issue,
  output logic [NoUnits-1:0]             req_allow,
  input  logic [NoUnits-1:0]             unit_resp_valid,
  output logic [NoUnits-1:0]             unit_resp_ready,
  input  logic [NoUnits*IdWidth-1:0]     unit_resp_id,
  input  logic [NoUnits*XlenWidth-1:0]   unit_resp_rd,
  input  logic [NoUnits*VlenWidth-1:0]   unit_resp_vd,
  input  logic [NoUnits-1:0]             unit_resp_rd_write,
  input  logic [NoUnits-1:0]             unit_resp_vd_write,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [IdWidth-1:0]             resp_id,
  output logic [XlenWidth-1:0]           resp_rd,
  output logic [VlenWidth-1:0]           resp_vd,
  output logic                           resp_rd_write,
  output logic                           resp_vd_write,
  output logic                           idle,
  output logic                           err
);

  localparam int CntW  = $clog2(MaxOutstanding + 1);
  localparam int PtrW  = (NoUnits > 1) ? $clog2(NoUnits) : 1;
  localparam int PtrW1 = PtrW + 1;

  logic [IdWidth-1:0]   id_arr [NoUnits];
  logic [XlenWidth-1:0] rd_arr [NoUnits];
  logic [VlenWidth-1:0] vd_arr [NoUnits];

  logic [NoUnits-1:0] cnt_zero;
  logic [NoUnits-1:0] ovf_vec;
  logic [NoUnits-1:0] unf_vec;

  logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IdWidth-1:0]   resp_id_q, resp_id_d;
  logic [XlenWidth-1:0] resp_rd_q, resp_rd_d;
  logic [VlenWidth-1:0] resp_vd_q, resp_vd_d;
  logic             resp_rd_write_q, resp_rd_write_d;
  logic             resp_vd_write_q, resp_vd_write_d;
  logic             err_q, err_d;

  logic [PtrW-1:0]  winner;
  logic [PtrW1-1:0] grant_sum;
  logic             found;
  logic             slot_free;
  logic             accept;

  // Round-robin search starting at rr_ptr_q, wrapping at NoUnits.
  always_comb begin
    winner    = '0;
    found     = 1'b0;
    grant_sum = '0;
    for (int k = 0; k < NoUnits; k++) begin
      grant_sum = {1'b0, rr_ptr_q} + PtrW1'(k);
      if (grant_sum >= PtrW1'(NoUnits)) begin
        grant_sum = grant_sum - PtrW1'(NoUnits);
      end
      if (!found && unit_resp_valid[grant_sum[PtrW-1:0]]) begin
        found  = 1'b1;
        winner = grant_sum[PtrW-1:0];
      end
    end
  end

  assign slot_free       = !resp_valid_q || resp_ready;
  assign accept          = found && slot_free;
  assign unit_resp_ready = accept ? (NoUnits'(1) << winner) : '0;

  for (genvar gi = 0; gi < NoUnits; gi++) begin : g_unit
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            inc, dec;

    assign id_arr[gi] = unit_resp_id[gi*IdWidth +: IdWidth];
    assign rd_arr[gi] = unit_resp_rd[gi*XlenWidth +: XlenWidth];
    assign vd_arr[gi] = unit_resp_vd[gi*VlenWidth +: VlenWidth];

    assign inc = req_issue[gi];
    assign dec = unit_resp_valid[gi] && unit_resp_ready[gi];

    // Saturate at both ends; a violation only raises the sticky error.
    assign ovf_vec[gi] = inc && !dec && (cnt_q == CntW'(MaxOutstanding));
    assign unf_vec[gi] = dec && !inc && (cnt_q == '0);

    always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec && !ovf_vec[gi]) begin
        cnt_d = cnt_q + CntW'(1);
      end else if (dec && !inc && !unf_vec[gi]) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign req_allow[gi] = (cnt_q < CntW'(MaxOutstanding));
    assign cnt_zero[gi]  = (cnt_q == '0);
  end

  // Accepting while the held beat drains reloads the slot: one beat per cycle.
  always_comb begin
    resp_valid_d    = resp_valid_q;
    resp_id_d       = resp_id_q;
    resp_rd_d       = resp_rd_q;
    resp_vd_d       = resp_vd_q;
    resp_rd_write_d = resp_rd_write_q;
    resp_vd_write_d = resp_vd_write_q;
    rr_ptr_d        = rr_ptr_q;
    if (accept) begin
      resp_valid_d    = 1'b1;
      resp_id_d       = id_arr[winner];
      resp_rd_d       = rd_arr[winner];
      resp_vd_d       = vd_arr[winner];
      resp_rd_write_d = unit_resp_rd_write[winner];
      resp_vd_write_d = unit_resp_vd_write[winner];
      rr_ptr_d        = (winner == PtrW'(NoUnits - 1)) ? '0 : winner + PtrW'(1);
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  assign err_d = err_q || (|ovf_vec) || (|unf_vec);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q        <= '0;
      resp_valid_q    <= 1'b0;
      resp_id_q       <= '0;
      resp_rd_q       <= '0;
      resp_vd_q       <= '0;
      resp_rd_write_q <= 1'b0;
      resp_vd_write_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      resp_valid_q    <= resp_valid_d;
      resp_id_q       <= resp_id_d;
      resp_rd_q       <= resp_rd_d;
      resp_vd_q       <= resp_vd_d;
      resp_rd_write_q <= resp_rd_write_d;
      resp_vd_write_q <= resp_vd_write_d;
      err_q           <= err_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_rd       = resp_rd_q;
  assign resp_vd       = resp_vd_q;
  assign resp_rd_write = resp_rd_write_q;
  assign resp_vd_write = resp_vd_write_q;
  assign err           = err_q;
  assign idle          = (&cnt_zero) && !resp_valid_q;

endmodule

// File: tb/tb_xadac_resp_sched.sv
// Bench for xadac_resp_sched: a negedge reference model feeds a response scoreboard
// and checks grants/credits every cycle; scenario tasks add directed checks.
`timescale 1ns/1ps
module tb_xadac_resp_sched;
  localparam int N = 4, IW = 4, XW = 32, VW = 256, MO = 4;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [XW-1:0] rd;
    logic [VW-1:0] vd;
    logic          rdw;
    logic          vdw;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_issue, req_allow, unit_resp_valid, unit_resp_ready;
  logic [N-1:0]    unit_resp_rd_write, unit_resp_vd_write;
  logic [N*IW-1:0] unit_resp_id;
  logic [N*XW-1:0] unit_resp_rd;
  logic [N*VW-1:0] unit_resp_vd;
  logic            resp_valid, resp_ready, resp_rd_write, resp_vd_write, idle, err;
  logic [IW-1:0]   resp_id;
  logic [XW-1:0]   resp_rd;
  logic [VW-1:0]   resp_vd;

  logic [IW-1:0] u_id [N];
  logic [XW-1:0] u_rd [N];
  logic [VW-1:0] u_vd [N];
  int pend [N];

  int checks = 0;
  int errors = 0;

  resp_t      sb [$];
  int         m_cnt [N];
  logic       m_err = 1'b0;
  logic [1:0] m_ptr = 2'd0;

  always #5 clk = ~clk;

  always_comb begin
    unit_resp_id = '0;
    unit_resp_rd = '0;
    unit_resp_vd = '0;
    for (int i = 0; i < N; i++) begin
      unit_resp_id[i*IW +: IW] = u_id[i];
      unit_resp_rd[i*XW +: XW] = u_rd[i];
      unit_resp_vd[i*VW +: VW] = u_vd[i];
    end
  end

  xadac_resp_sched #(
    .NoUnits(N), .IdWidth(IW), .XlenWidth(XW), .VlenWidth(VW), .MaxOutstanding(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_issue(req_issue), .req_allow(req_allow),
    .unit_resp_valid(unit_resp_valid), .unit_resp_ready(unit_resp_ready),
    .unit_resp_id(unit_resp_id), .unit_resp_rd(unit_resp_rd), .unit_resp_vd(unit_resp_vd),
    .unit_resp_rd_write(unit_resp_rd_write), .unit_resp_vd_write(unit_resp_vd_write),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_rd(resp_rd), .resp_vd(resp_vd),
    .resp_rd_write(resp_rd_write), .resp_vd_write(resp_vd_write),
    .idle(idle), .err(err)
  );

  // Reference model: evaluated mid-cycle, state advanced as of the next posedge.
  always @(negedge clk) begin : mon
    logic [N-1:0] exp_rdy, exp_allow;
    logic [1:0]   idx, w;
    logic         found, m_idle, inc, dec;
    resp_t        got, pushed;
    exp_allow = '0;
    m_idle = (sb.size() == 0);
    for (int i = 0; i < N; i++) begin
      exp_allow[i] = (m_cnt[i] < MO);
      if (m_cnt[i] != 0) m_idle = 1'b0;
    end
    found = 1'b0;
    w = 2'd0;
    for (int k = 0; k < N; k++) begin
      idx = m_ptr + 2'(k);
      if (!found && unit_resp_valid[idx]) begin
        found = 1'b1;
        w = idx;
      end
    end
    exp_rdy = '0;
    if (found && (sb.size() == 0 || resp_ready)) exp_rdy[w] = 1'b1;

    checks++;
    if (resp_valid !== (sb.size() != 0)) begin
      errors++;
      $display("FAIL sb_valid: resp_valid=%b expected=%b", resp_valid, sb.size() != 0);
    end
    checks++;
    if (req_allow !== exp_allow) begin
      errors++;
      $display("FAIL model_allow: req_allow=%b expected=%b", req_allow, exp_allow);
    end
    checks++;
    if (idle !== m_idle) begin
      errors++;
      $display("FAIL model_idle: idle=%b expected=%b", idle, m_idle);
    end
    checks++;
    if (err !== m_err) begin
      errors++;
      $display("FAIL model_err: err=%b expected=%b", err, m_err);
    end
    checks++;
    if (unit_resp_ready !== exp_rdy) begin
      errors++;
      $display("FAIL model_grant: unit_resp_ready=%b expected=%b", unit_resp_ready, exp_rdy);
    end
    got = {resp_id, resp_rd, resp_vd, resp_rd_write, resp_vd_write};
    if (sb.size() != 0) begin
      checks++;
      if (got !== sb[0]) begin
        errors++;
        $display("FAIL sb_payload: id=%h rd=%h rdw=%b vdw=%b vd=%h expected id=%h rd=%h rdw=%b vdw=%b vd=%h",
                 got.id, got.rd, got.rdw, got.vdw, got.vd,
                 sb[0].id, sb[0].rd, sb[0].rdw, sb[0].vdw, sb[0].vd);
      end
    end

    if (rst) begin
      sb.delete();
      m_ptr = 2'd0;
      m_err = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      if (sb.size() != 0 && resp_ready) begin
        $display("resp out: id=%h rd=%h rdw=%b vdw=%b", sb[0].id, sb[0].rd, sb[0].rdw, sb[0].vdw);
        void'(sb.pop_front());
      end
      if (exp_rdy != '0) begin
        pushed = {u_id[w], u_rd[w], u_vd[w], unit_resp_rd_write[w], unit_resp_vd_write[w]};
        sb.push_back(pushed);
        m_ptr = w + 2'd1;
      end
      for (int i = 0; i < N; i++) begin
        inc = req_issue[i];
        dec = exp_rdy[i];
        if (inc && !dec) begin
          if (m_cnt[i] == MO) m_err = 1'b1;
          else m_cnt[i]++;
        end else if (dec && !inc) begin
          if (m_cnt[i] == 0) m_err = 1'b1;
          else m_cnt[i]--;
        end
      end
    end
  end

  task automatic new_payload(input int i, input logic [IW-1:0] id, input logic rdw, input logic vdw);
    u_id[i] = id;
    u_rd[i] = $urandom;
    for (int j = 0; j < VW / 32; j++) u_vd[i][j*32 +: 32] = $urandom;
    unit_resp_rd_write[i] = rdw;
    unit_resp_vd_write[i] = vdw;
  endtask

  task automatic start_unit(input int i, input int n, input logic [IW-1:0] id,
                            input logic rdw, input logic vdw);
    pend[i] = n;
    new_payload(i, id, rdw, vdw);
    unit_resp_valid[i] = 1'b1;
  endtask

  // One clock: units that handshook this cycle present their next response or drop valid.
  task automatic cyc();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = unit_resp_valid & unit_resp_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        pend[i]--;
        if (pend[i] > 0) new_payload(i, u_id[i] + 4'd1, ~unit_resp_rd_write[i], unit_resp_vd_write[i]);
        else unit_resp_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((unit_resp_valid != '0 || resp_valid) && n < 40) begin
      cyc();
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    checks++;
    if (idle !== 1'b1 || req_allow !== 4'b1111 || resp_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: idle=%b allow=%b valid=%b err=%b required 1 1111 0 0",
               idle, req_allow, resp_valid, err);
    end
    checks++;
    if (resp_id !== '0 || resp_rd !== '0 || resp_vd !== '0 || resp_rd_write !== 1'b0 || resp_vd_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_payload: id=%h rd=%h rdw=%b vdw=%b required zeros", resp_id, resp_rd, resp_rd_write, resp_vd_write);
    end
  endtask

  task automatic test_single();
    req_issue = 4'b0100;
    cyc();
    req_issue = '0;
    checks++;
    if (idle !== 1'b0) begin
      errors++;
      $display("FAIL single_busy: idle=%b required 0", idle);
    end
    resp_ready = 1'b1;
    start_unit(2, 1, 4'd5, 1'b0, 1'b1);
    #1;
    checks++;
    if (unit_resp_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: unit_resp_ready=%b required 0100", unit_resp_ready);
    end
    cyc();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 4'd5 || resp_vd_write !== 1'b1 || resp_rd_write !== 1'b0) begin
      errors++;
      $display("FAIL single_out: valid=%b id=%h vdw=%b rdw=%b required 1 5 1 0",
               resp_valid, resp_id, resp_vd_write, resp_rd_write);
    end
    cyc();
    checks++;
    if (resp_valid !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL single_drain: valid=%b idle=%b required 0 1", resp_valid, idle);
    end
  endtask

  task automatic test_round_robin();
    logic [IW-1:0] exp_ids [5] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd1};
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req_issue = 4'b1111;
    cyc();
    req_issue = 4'b0001;
    cyc();
    req_issue = '0;
    resp_ready = 1'b1;
    start_unit(0, 2, 4'd0, 1'b1, 1'b0);
    start_unit(1, 1, 4'd4, 1'b1, 1'b1);
    start_unit(2, 1, 4'd8, 1'b0, 1'b1);
    start_unit(3, 1, 4'd12, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== exp_ids[k]) begin
        errors++;
        $display("FAIL rr_beat%0d: valid=%b id=%h required 1 %h", k, resp_valid, resp_id, exp_ids[k]);
      end
    end
    cyc();
    checks++;
    if (resp_valid !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL rr_end: valid=%b idle=%b required 0 1", resp_valid, idle);
    end
  endtask

  task automatic test_backpressure();
    req_issue = 4'b1010;
    cyc();
    req_issue = '0;
    resp_ready = 1'b0;
    start_unit(1, 1, 4'd3, 1'b1, 1'b0);
    start_unit(3, 1, 4'd7, 1'b0, 1'b1);
    cyc();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 4'd3) begin
      errors++;
      $display("FAIL bp_first: valid=%b id=%h required 1 3", resp_valid, resp_id);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (unit_resp_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_stall_ready%0d: unit_resp_ready=%b required 0000", k, unit_resp_ready);
      end
      cyc();
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 4'd3) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b id=%h required 1 3", k, resp_valid, resp_id);
      end
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (unit_resp_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release_grant: unit_resp_ready=%b required 1000", unit_resp_ready);
    end
    cyc();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 4'd7) begin
      errors++;
      $display("FAIL bp_reload: valid=%b id=%h required 1 7", resp_valid, resp_id);
    end
    drain("bp");
  endtask

  task automatic test_credit_limit();
    for (int k = 0; k < 4; k++) begin
      req_issue = 4'b0001;
      cyc();
    end
    req_issue = '0;
    checks++;
    if (req_allow !== 4'b1110 || err !== 1'b0) begin
      errors++;
      $display("FAIL credit_full: allow=%b err=%b required 1110 0", req_allow, err);
    end
    req_issue = 4'b0001;
    cyc();
    req_issue = '0;
    checks++;
    if (err !== 1'b1 || req_allow !== 4'b1110) begin
      errors++;
      $display("FAIL credit_overflow: err=%b allow=%b required 1 1110", err, req_allow);
    end
    req_issue = 4'b0001;
    resp_ready = 1'b1;
    start_unit(0, 5, 4'd2, 1'b1, 1'b1);
    cyc();
    req_issue = '0;
    checks++;
    if (req_allow !== 4'b1110 || err !== 1'b1) begin
      errors++;
      $display("FAIL credit_same_cycle: allow=%b err=%b required 1110 1", req_allow, err);
    end
    drain("credit");
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL credit_saturated_count: idle=%b required 1 after four returns", idle);
    end
  endtask

  task automatic test_reset_mid();
    req_issue = 4'b1010;
    cyc();
    req_issue = 4'b0010;
    cyc();
    cyc();
    req_issue = '0;
    resp_ready = 1'b0;
    start_unit(1, 1, 4'd9, 1'b1, 1'b0);
    cyc();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 4'd9) begin
      errors++;
      $display("FAIL mid_loaded: valid=%b id=%h required 1 9", resp_valid, resp_id);
    end
    unit_resp_valid = '0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || idle !== 1'b1 || req_allow !== 4'b1111 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b idle=%b allow=%b err=%b required 0 1 1111 0",
               resp_valid, idle, req_allow, err);
    end
    req_issue = 4'b1010;
    cyc();
    req_issue = '0;
    resp_ready = 1'b1;
    start_unit(1, 1, 4'd10, 1'b0, 1'b0);
    start_unit(3, 1, 4'd11, 1'b1, 1'b1);
    #1;
    checks++;
    if (unit_resp_ready !== 4'b0010) begin
      errors++;
      $display("FAIL mid_ptr_reset: unit_resp_ready=%b required 0010", unit_resp_ready);
    end
    drain("mid");
    checks++;
    if (idle !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_end: idle=%b err=%b required 1 0", idle, err);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_issue = '0;
    resp_ready = 1'b0;
    unit_resp_valid = '0;
    unit_resp_rd_write = '0;
    unit_resp_vd_write = '0;
    for (int i = 0; i < N; i++) begin
      u_id[i] = '0;
      u_rd[i] = '0;
      u_vd[i] = '0;
      pend[i] = 0;
      m_cnt[i] = 0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_credit_limit();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
